// File: rtl/ad9361_tx_pacer_if.sv
// FIFO-to-pacer stream handshake: {Q,I} data, valid from the FIFO, ready (read strobe) back.
interface ad9361_tx_pacer_if #(
  parameter int unsigned DATA_W = 12
);
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);
endinterface

// File: rtl/ad9361_tx_pacer.sv
// AD9361 TX sample pacer: one FIFO read per INTERP cycles, priming and underflow detection.
// Define TX_PACER_HOLD_EN to hold the last accepted sample on empty slots instead of zeroing.
module ad9361_tx_pacer #(
  parameter int unsigned INTERP         = 12,
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned PRIME_SLOTS    = 4,
  parameter int unsigned UNDERRUN_LIMIT = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 AD9361_CLK,
  input  logic                 rst_32d768M,
  ad9361_tx_pacer_if.slave     fifo,
  output logic [DATA_W-1:0]    tx_I,
  output logic [DATA_W-1:0]    tx_Q,
  output logic                 tx_strobe,
  output logic                 running,
  output logic                 underflow,
  output logic [CNT_W-1:0]     underflow_cnt
);

  localparam int unsigned SLOT_W  = $clog2(INTERP);
  localparam int unsigned PRIME_W = (PRIME_SLOTS > 1) ? $clog2(PRIME_SLOTS) : 1;
  localparam int unsigned EMPTY_W = $clog2(UNDERRUN_LIMIT + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(INTERP - 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_SLOTS - 1);
  localparam logic [EMPTY_W-1:0] EMPTY_LAST = EMPTY_W'(UNDERRUN_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;

  // Reset synchronizer: asserts asynchronously, releases on the 2nd clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge AD9361_CLK or posedge rst_32d768M) begin
    if (rst_32d768M) rst_sync_q <= 2'b11;
    else             rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PRIME_W-1:0]  prime_q, prime_d;
  logic [EMPTY_W-1:0]  empty_q, empty_d;
  logic [DATA_W-1:0]   tx_i_q, tx_i_d;
  logic [DATA_W-1:0]   tx_q_q, tx_q_d;
  logic                strobe_q, strobe_d;
  logic                uflow_q, uflow_d;
  logic [CNT_W-1:0]    ucnt_q, ucnt_d;
  logic                ready_q, ready_d;
  logic                running_q, running_d;
  logic [SLOT_W-1:0]   slot_inc;

  always_ff @(posedge AD9361_CLK or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      prime_q   <= '0;
      empty_q   <= '0;
      tx_i_q    <= '0;
      tx_q_q    <= '0;
      strobe_q  <= 1'b0;
      uflow_q   <= 1'b0;
      ucnt_q    <= '0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      prime_q   <= prime_d;
      empty_q   <= empty_d;
      tx_i_q    <= tx_i_d;
      tx_q_q    <= tx_q_d;
      strobe_q  <= strobe_d;
      uflow_q   <= uflow_d;
      ucnt_q    <= ucnt_d;
      ready_q   <= ready_d;
      running_q <= running_d;
    end
  end

  assign slot_inc = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

  // Next-state and output decode; ready_q is high exactly on slot 0 of RUN.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    prime_d  = prime_q;
    empty_d  = empty_q;
    tx_i_d   = tx_i_q;
    tx_q_d   = tx_q_q;
    strobe_d = 1'b0;
    uflow_d  = 1'b0;
    ucnt_d   = ucnt_q;

    case (state_q)
      IDLE: begin
        slot_d  = '0;
        prime_d = '0;
        empty_d = '0;
        tx_i_d  = '0;
        tx_q_d  = '0;
        if (fifo.s_tvalid) state_d = ARM;
      end
      ARM: begin
        slot_d = slot_inc;
        if (slot_q == SLOT_LAST) begin
          if (prime_q == PRIME_LAST) begin
            state_d = RUN;
            prime_d = '0;
          end else begin
            prime_d = prime_q + PRIME_W'(1);
          end
        end
      end
      RUN: begin
        slot_d = slot_inc;
        if (ready_q) begin
          if (fifo.s_tvalid) begin
            tx_i_d   = fifo.s_tdata[DATA_W-1:0];
            tx_q_d   = fifo.s_tdata[2*DATA_W-1:DATA_W];
            strobe_d = 1'b1;
            empty_d  = '0;
          end else begin
            uflow_d = 1'b1;
            if (ucnt_q != '1) ucnt_d = ucnt_q + CNT_W'(1);
            empty_d = empty_q + EMPTY_W'(1);
`ifndef TX_PACER_HOLD_EN
            tx_i_d = '0;
            tx_q_d = '0;
`endif
            // Final empty slot of an underrun: leave RUN with outputs cleared.
            if (empty_q == EMPTY_LAST) begin
              state_d = IDLE;
              slot_d  = '0;
              empty_d = '0;
              tx_i_d  = '0;
              tx_q_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d   = (state_d == RUN) && (slot_d == '0);
  assign running_d = (state_d == RUN);

  assign fifo.s_tready = ready_q;
  assign tx_I          = tx_i_q;
  assign tx_Q          = tx_q_q;
  assign tx_strobe     = strobe_q;
  assign running       = running_q;
  assign underflow     = uflow_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: doc/ad9361_tx_pacer.md
# ad9361_tx_pacer

Transmit-side sample pacer in the AD9361_CLK domain. It pulls {Q,I} words from the DAC async FIFO's master side at one word per INTERP AD9361_CLK cycles and holds each word on the AD9361 TX data inputs for the full slot. It also primes the FIFO after start-up and detects underflow. It replaces the permanently-asserted FIFO tready and mirrors the receive-side decimate-by-12 write strobe.

## Interface
- INTERP, 12, AD9361_CLK cycles per TX sample slot; must be ≥2.
- DATA_W, 12, width of I and of Q.
- PRIME_SLOTS, 4, slots to wait after the first valid before the first read; must be ≥1.
- UNDERRUN_LIMIT, 8, consecutive empty slots that force a return to IDLE; must be ≥1.
- CNT_W, 16, width of the underflow counter.

- AD9361_CLK  in  1  clock (AD9361 DATACLK-derived).
- rst_32d768M  in  1  reset, asynchronous, active-high; clock AD9361_CLK.
- s_tdata  in  2*DATA_W  FIFO master data, {Q, I}.
- s_tvalid  in  1  FIFO master valid.
- s_tready  out  1  read strobe to the FIFO.
- tx_I  out  DATA_W  I sample to the AD9361 TX interface.
- tx_Q  out  DATA_W  Q sample to the AD9361 TX interface.
- tx_strobe  out  1  one-cycle pulse when tx_I/tx_Q load an accepted sample.
- running  out  1  high while in RUN.
- underflow  out  1  one-cycle pulse for each empty slot in RUN.
- underflow_cnt  out  CNT_W  saturating total of empty slots.

## Operation
- **Reset synchronizer.**
  - Internal two-flop chain. Asserts asynchronously on rst_32d768M.
  - Deasserts on the 2nd AD9361_CLK rising edge after rst_32d768M falls.
  - All other flops are reset by the chain output.
- **Slot counter `slot`.**
  - Range 0..INTERP-1, wraps to 0.
  - Held at 0 in IDLE; free-running in ARM and RUN.
- **State machine** (IDLE, ARM, RUN):
  - **IDLE:**
    - s_tready=0; tx_I/tx_Q forced to 0.
    - Goes to ARM on the first cycle with s_tvalid=1.
  - **ARM:**
    - s_tready=0. Prime counter increments each time slot==INTERP-1.
    - Goes to RUN when slot==INTERP-1 and the prime counter is PRIME_SLOTS-1.
    - The s_tvalid level is ignored in ARM.
  - **RUN:**
    - s_tready = (slot==0), decoded from registers only, with no combinational path from s_tvalid.
    - **Accept** (slot==0 and s_tvalid=1): load tx_I=s_tdata[DATA_W-1:0] and tx_Q=s_tdata[2*DATA_W-1:DATA_W]; pulse tx_strobe; clear the consecutive-empty counter.
    - **Empty slot** (slot==0 and s_tvalid=0):
      - pulse underflow;
      - underflow_cnt += 1, saturating at all-ones;
      - consecutive-empty counter += 1;
      - update tx_I/tx_Q per Configuration.
    - Goes to IDLE when the consecutive-empty counter reaches UNDERRUN_LIMIT, on the same edge as the final empty slot. running falls on that edge and outputs read 0 from the next cycle.
- underflow_cnt is cleared only by reset. It keeps counting across IDLE/RUN round trips.

## Timing
- **Reset value:** every output is 0 (s_tready, tx_I, tx_Q, tx_strobe, running, underflow, underflow_cnt).
- **Latency:** tx_I/tx_Q/tx_strobe update on the edge that ends the slot-0 cycle, so they are visible one cycle after s_tready is high.
- **Output holding:** tx_I/tx_Q hold for exactly INTERP cycles between loads.
- **Start-up timing:**
  - The first s_tready rises PRIME_SLOTS*INTERP cycles after the IDLE→ARM edge (default 48).
  - s_tready then repeats every INTERP cycles.
- **Handshake:**
  - A transfer occurs only on an edge where s_tready and s_tvalid are both high.
  - s_tready is never high for two consecutive cycles.
- **Reset mid-operation:**
  - On assertion, outputs go to 0 immediately (asynchronous) and all state clears.
  - Recovery requires the 2-edge synchronizer, then IDLE, then a full prime.
- **Simultaneous events:** the final empty slot and the RUN→IDLE exit occur on the same edge; the underflow pulse and underflow_cnt increment are still produced.

## Configuration
- **TX_PACER_HOLD_EN defined:** on an empty slot in RUN, tx_I/tx_Q keep the last accepted sample.
- **TX_PACER_HOLD_EN not defined:** on an empty slot in RUN, tx_I/tx_Q load 0.
- IDLE forces 0 either way.

## Test plan
- **Prime and stream:** reset, then s_tvalid held 1 with s_tdata = {Q=0x800+n, I=n}.
  - s_tready first high 48 cycles after ARM entry, then every 12 cycles.
  - tx_I = 0,1,2… each held 12 cycles; tx_strobe at every load.
- **Single gap:** drop s_tvalid during one slot-0 cycle in RUN.
  - underflow pulses once and underflow_cnt=1.
  - With TX_PACER_HOLD_EN, tx_I repeats the previous value; without it, tx_I=0 for that slot.
  - The next slot resumes normal loading.
- **Underrun exit:** hold s_tvalid=0 for 8 slots in RUN.
  - underflow_cnt=8; running falls on the 8th empty-slot edge; s_tready stays 0.
  - Restoring s_tvalid re-primes: first s_tready 48 cycles later.
- **Reset mid-RUN:** pulse rst_32d768M for 3 cycles.
  - All outputs 0 within the assertion cycle.
  - No s_tready until 2 edges after deassertion plus IDLE→ARM plus 48 cycles.
- **Saturation:** run with CNT_W=4 and UNDERRUN_LIMIT=20, then 20 empty slots.
  - underflow_cnt stops at 15.
  - Back in IDLE after the 20th empty slot.
